// File: rtl/hdmi_audio_sched.sv
// Audio sample scheduler for hdmi_tx: exact-average fs strobe from a fractional phase accumulator, src0/src1 arbitration.
// Build option HDMI_AUDIO_SCHED_HOLD_EN: an underrun repeats the last sample instead of outputting zero.
module hdmi_audio_sched #(
  parameter int CLOCK_HZ   = 74286000,
  parameter int FS_HZ      = 44100,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int ACC_W      = 32
) (
  input  logic                          vga_clk_sig,
  input  logic                          reset_sig,
  input  logic [1:0]                    sel_mode,
  input  logic [DATA_W-1:0]             src0_l,
  input  logic [DATA_W-1:0]             src0_r,
  input  logic                          src1_valid,
  output logic                          src1_ready,
  input  logic [DATA_W-1:0]             src1_l,
  input  logic [DATA_W-1:0]             src1_r,
  output logic                          pcm_fs,
  output logic [DATA_W-1:0]             pcm_l,
  output logic [DATA_W-1:0]             pcm_r,
  output logic                          active_src,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [ACC_W-1:0] CLK_C    = ACC_W'(CLOCK_HZ);
  localparam logic [ACC_W-1:0] FS_C     = ACC_W'(FS_HZ);
  localparam logic [ACC_W-1:0] HALF_C   = ACC_W'(CLOCK_HZ / 2);
  localparam logic [LVL_W-1:0] FULL_C   = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] SWITCH_C = LVL_W'(FIFO_DEPTH / 2);

  typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} src_t;

  // Phase accumulator: adds FS_HZ per cycle, wraps by CLOCK_HZ, so ticks average exactly FS_HZ.
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] acc_next;
  logic             tick;

  always_comb begin
    acc_sum  = acc + FS_C;
    tick     = (acc_sum >= CLK_C);
    acc_next = tick ? (acc_sum - CLK_C) : acc_sum;
  end

  always_ff @(posedge vga_clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      acc    <= '0;
      pcm_fs <= 1'b0;
    end else begin
      acc <= acc_next;
      if (tick)
        pcm_fs <= 1'b1;
      else if ((acc_next >= HALF_C) && (acc < HALF_C))
        pcm_fs <= 1'b0;
    end
  end

  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    level;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic [DATA_W-1:0]   head_l;
  logic [DATA_W-1:0]   head_r;

  assign full       = (level == FULL_C);
  assign empty      = (level == '0);
  assign src1_ready = ~full;
  assign push       = src1_valid & ~full;
  assign fifo_level = level;
  assign head_l     = mem[rd_ptr][2*DATA_W-1:DATA_W];
  assign head_r     = mem[rd_ptr][DATA_W-1:0];

  always_ff @(posedge vga_clk_sig) begin
    if (push)
      mem[wr_ptr] <= {src1_l, src1_r};
  end

  always_ff @(posedge vga_clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Source decision for the coming tick; the new source applies to that same tick.
  src_t state;
  src_t state_next;
  logic mute;
  logic use_src1;

  always_comb begin
    state_next = state;
    unique case (sel_mode)
      2'b00: begin
        if (state == SRC0) begin
          if (level >= SWITCH_C)
            state_next = SRC1;
        end else if (empty) begin
          state_next = SRC0;
        end
      end
      2'b01:   state_next = SRC0;
      2'b10:   state_next = SRC1;
      default: state_next = state;
    endcase
    mute     = (sel_mode == 2'b11);
    use_src1 = !mute && (state_next == SRC1);
    pop      = tick && use_src1 && !empty;
  end

  always_ff @(posedge vga_clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state    <= SRC0;
      pcm_l    <= '0;
      pcm_r    <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (tick) begin
        state <= state_next;
        if (mute) begin
          pcm_l <= '0;
          pcm_r <= '0;
        end else if (!use_src1) begin
          pcm_l <= src0_l;
          pcm_r <= src0_r;
        end else if (!empty) begin
          pcm_l <= head_l;
          pcm_r <= head_r;
        end else begin
          underrun <= 1'b1;
`ifdef HDMI_AUDIO_SCHED_HOLD_EN
          pcm_l <= pcm_l;
          pcm_r <= pcm_r;
`else
          pcm_l <= '0;
          pcm_r <= '0;
`endif
        end
      end
    end
  end

  assign active_src = (state == SRC1);

endmodule

// File: tb/tb_hdmi_audio_sched.sv
// Bench for hdmi_audio_sched: directed scenarios plus randomized traffic against a queue-based model.
module tb_hdmi_audio_sched;
  localparam int CLK_HZ = 1000;
  localparam int FS     = 300;
  localparam int DW     = 24;
  localparam int DEPTH  = 4;
`ifdef HDMI_AUDIO_SCHED_HOLD_EN
  localparam logic [DW-1:0] UND_L = 24'h00C0DE;
`else
  localparam logic [DW-1:0] UND_L = 24'h000000;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    sel_mode = 2'b00;
  logic [DW-1:0] src0_l = 24'h0A0A0A;
  logic [DW-1:0] src0_r = 24'h0B0B0B;
  logic          src1_valid = 1'b0;
  logic [DW-1:0] src1_l = '0;
  logic [DW-1:0] src1_r = '0;
  logic          src1_ready, pcm_fs, active_src, underrun;
  logic [DW-1:0] pcm_l, pcm_r;
  logic [2:0]    fifo_level;

  logic [1:0]    b_mode = 2'b01;
  logic [DW-1:0] b_src_l = 24'h123456;
  logic [DW-1:0] b_src_r = 24'hABCDEF;
  logic [DW-1:0] b_zero = '0;
  logic          b_valid = 1'b0;
  logic          b_ready, b_fs, b_act, b_und;
  logic [DW-1:0] b_pcm_l, b_pcm_r;
  logic [2:0]    b_level;

  int n_pass = 0;
  int n_total = 0;
  bit frac_done = 1'b0;

  always #5 clk = ~clk;

  hdmi_audio_sched #(.CLOCK_HZ(CLK_HZ), .FS_HZ(FS), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .ACC_W(32)) dut (
    .vga_clk_sig(clk), .reset_sig(reset), .sel_mode(sel_mode),
    .src0_l(src0_l), .src0_r(src0_r),
    .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_l(src1_l), .src1_r(src1_r),
    .pcm_fs(pcm_fs), .pcm_l(pcm_l), .pcm_r(pcm_r),
    .active_src(active_src), .underrun(underrun), .fifo_level(fifo_level)
  );

  hdmi_audio_sched #(.CLOCK_HZ(1000), .FS_HZ(100), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .ACC_W(32)) dut_b (
    .vga_clk_sig(clk), .reset_sig(reset), .sel_mode(b_mode),
    .src0_l(b_src_l), .src0_r(b_src_r),
    .src1_valid(b_valid), .src1_ready(b_ready), .src1_l(b_zero), .src1_r(b_zero),
    .pcm_fs(b_fs), .pcm_l(b_pcm_l), .pcm_r(b_pcm_r),
    .active_src(b_act), .underrun(b_und), .fifo_level(b_level)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
  endtask

  task automatic wait_tick();
    logic prev;
    bit   ok;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      prev = pcm_fs;
      @(posedge clk);
      #1;
      if (pcm_fs && !prev) ok = 1'b1;
    end
    if (!ok) begin
      n_total++;
      $display("FAIL wait_tick: got no pcm_fs rise required one within 40 cycles at %0t", $time);
    end
  endtask

  // Model: tick at edge n when floor(n*FS/CLK) steps; pcm_fs high while the phase is in its first half.
  logic [2*DW-1:0] q[$];
  int unsigned     n_edge = 0;
  bit              m_src1 = 1'b0, m_fs = 1'b0, m_und = 1'b0;
  logic [DW-1:0]   m_l = '0, m_r = '0;

  initial forever begin
    bit              tick, push;
    logic [2*DW-1:0] w;
    @(posedge clk or posedge reset);
    if (reset) begin
      n_edge = 0; q.delete(); m_src1 = 1'b0; m_fs = 1'b0; m_und = 1'b0; m_l = '0; m_r = '0;
    end else begin
      n_edge++;
      tick  = ((n_edge * FS) / CLK_HZ) != (((n_edge - 1) * FS) / CLK_HZ);
      push  = src1_valid && (q.size() < DEPTH);
      m_und = 1'b0;
      if (tick) begin
        case (sel_mode)
          2'b00:   m_src1 = m_src1 ? (q.size() != 0) : (q.size() >= DEPTH / 2);
          2'b01:   m_src1 = 1'b0;
          2'b10:   m_src1 = 1'b1;
          default: m_src1 = m_src1;
        endcase
        if (sel_mode == 2'b11) begin
          m_l = '0; m_r = '0;
        end else if (!m_src1) begin
          m_l = src0_l; m_r = src0_r;
        end else if (q.size() != 0) begin
          w = q.pop_front();
          m_l = w[2*DW-1:DW]; m_r = w[DW-1:0];
        end else begin
          m_und = 1'b1;
`ifndef HDMI_AUDIO_SCHED_HOLD_EN
          m_l = '0; m_r = '0;
`endif
        end
      end
      if (push) q.push_back({src1_l, src1_r});
      m_fs = (n_edge * FS >= CLK_HZ) && (((n_edge * FS) % CLK_HZ) < CLK_HZ / 2);
    end
  end

  initial forever begin
    @(negedge clk);
    check("cmp_fs", pcm_fs, m_fs);
    check("cmp_pcm_l", pcm_l, m_l);
    check("cmp_pcm_r", pcm_r, m_r);
    check("cmp_active", active_src, m_src1);
    check("cmp_underrun", underrun, m_und);
    check("cmp_level", fifo_level, 64'(q.size()));
    check("cmp_ready", src1_ready, q.size() < DEPTH);
  end

  // 1000 Hz clock, 100 Hz fs: strict 10-cycle period, 5 cycles high.
  initial begin
    int  k, last_rise;
    bit  prev;
    @(negedge reset);
    prev = 1'b0; k = 0; last_rise = 0;
    for (int n = 1; n <= 46; n++) begin
      @(negedge clk);
      if (b_fs && !prev) begin
        k++;
        check("b_rise_cycle", n, 10 * k);
        check("b_pcm_l", b_pcm_l, 24'h123456);
        check("b_pcm_r", b_pcm_r, 24'hABCDEF);
        last_rise = n;
      end
      if (!b_fs && prev) check("b_high_len", n - last_rise, 5);
      prev = b_fs;
    end
    check("b_rise_count", k, 4);
    check("b_underrun", b_und, 0);
    check("b_active", b_act, 0);
    check("b_level", b_level, 0);
    check("b_ready", b_ready, 1);
  end

  // 1000 Hz clock, 300 Hz fs: 3000 ticks in 10000 cycles, spacing 3 or 4.
  initial begin
    int cnt, last, iv;
    bit prev;
    @(negedge reset);
    cnt = 0; last = 0; prev = 1'b0;
    for (int n = 1; n <= 10000; n++) begin
      @(negedge clk);
      if (pcm_fs && !prev) begin
        cnt++;
        iv = n - last;
        check("frac_interval", iv, (iv <= 3) ? 3 : 4);
        last = n;
      end
      prev = pcm_fs;
    end
    check("frac_ticks", cnt, 3000);
    frac_done = 1'b1;
  end

  initial begin
    int rate, first;
    rate = 5;
    #1 reset = 1'b1;
    #11;
    check("rst_fs", pcm_fs, 0);
    check("rst_pcm_l", pcm_l, 0);
    check("rst_pcm_r", pcm_r, 0);
    check("rst_active", active_src, 0);
    check("rst_underrun", underrun, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", src1_ready, 1);
    #10 reset = 1'b0;

    // Auto: two queued samples switch to src1, then back to src0 once drained.
    wait_tick();
    src1_valid = 1'b1; src1_l = 24'd1; src1_r = 24'd1;
    @(posedge clk); #1;
    src1_l = 24'd2; src1_r = 24'd2;
    @(posedge clk); #1;
    src1_valid = 1'b0;
    check("auto_level", fifo_level, 2);
    wait_tick();
    check("auto_first_l", pcm_l, 1);
    check("auto_first_r", pcm_r, 1);
    check("auto_first_active", active_src, 1);
    wait_tick();
    check("auto_second_l", pcm_l, 2);
    check("auto_second_active", active_src, 1);
    wait_tick();
    check("auto_back_l", pcm_l, 24'h0A0A0A);
    check("auto_back_r", pcm_r, 24'h0B0B0B);
    check("auto_back_active", active_src, 0);
    check("auto_back_underrun", underrun, 0);

    // Full FIFO under mute, then a forced-src1 pop with valid still high.
    sel_mode = 2'b11; src1_valid = 1'b1; src1_l = 24'h00C0DE; src1_r = 24'h00BEEF;
    repeat (6) @(posedge clk);
    #1;
    check("full_level", fifo_level, 4);
    check("full_ready", src1_ready, 0);
    sel_mode = 2'b10;
    wait_tick();
    check("pop_level", fifo_level, 3);
    check("pop_l", pcm_l, 24'h00C0DE);
    check("pop_active", active_src, 1);
    @(posedge clk); #1;
    check("refill_level", fifo_level, 4);
    check("refill_ready", src1_ready, 0);
    src1_valid = 1'b0;

    // Forced src1 with an empty FIFO.
    repeat (4) wait_tick();
    check("drained_level", fifo_level, 0);
    for (int t = 0; t < 2; t++) begin
      wait_tick();
      check("und_pulse", underrun, 1);
      check("und_l", pcm_l, UND_L);
      @(posedge clk); #1;
      check("und_width", underrun, 0);
    end

    for (int c = 0; c < 10300; c++) begin
      @(posedge clk); #2;
      if (c % 200 == 0) rate = int'($urandom_range(1, 9));
      if (c % 37 == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: sel_mode = 2'b00;
          5, 6:          sel_mode = 2'b01;
          7, 8:          sel_mode = 2'b10;
          default:       sel_mode = 2'b11;
        endcase
      end
      if (c % 53 == 0) begin
        src0_l = 24'($urandom); src0_r = 24'($urandom);
      end
      src1_valid = (int'($urandom_range(0, 9)) < rate);
      src1_l = 24'($urandom); src1_r = 24'($urandom);
    end
    for (int k = 0; k < 20000 && !frac_done; k++) @(posedge clk);
    check("frac_done", frac_done, 1);

    // Reset mid-operation with level 3 and pcm_fs high.
    sel_mode = 2'b10; src1_valid = 1'b0;
    for (int k = 0; k < 12 && fifo_level != 0; k++) wait_tick();
    sel_mode = 2'b11; src1_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    src1_valid = 1'b0;
    check("mid_level", fifo_level, 3);
    for (int k = 0; k < 20 && !pcm_fs; k++) begin
      @(posedge clk); #1;
    end
    check("mid_fs_high", pcm_fs, 1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_fs", pcm_fs, 0);
    check("mid_rst_pcm_l", pcm_l, 0);
    check("mid_rst_pcm_r", pcm_r, 0);
    check("mid_rst_active", active_src, 0);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ready", src1_ready, 1);
    @(posedge clk); #2 reset = 1'b0;
    first = 0;
    for (int k = 1; k <= 12 && first == 0; k++) begin
      @(posedge clk); #1;
      if (pcm_fs) first = k;
    end
    check("first_tick_after_reset", first, 4);
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hdmi_audio_sched.md
Name: hdmi_audio_sched

Overview:
- Audio sample scheduler in front of the hdmi_tx PCM inputs.
- Generates an exact-average fs strobe from the video clock with a fractional phase accumulator, so 44.1 kHz from 74.286 MHz carries no integer-divider error.
- Arbitrates between two sample sources: src0, a free-running level source such as the melody chime, and src1, a valid/ready stream buffered in a small FIFO.
- Presents one stereo sample plus pcm_fs per period.

Parameters:
- CLOCK_HZ, 74286000, video clock frequency in Hz.
- FS_HZ, 44100, audio sample rate in Hz; must be less than CLOCK_HZ/2.
- DATA_W, 24, PCM sample width (two's complement).
- FIFO_DEPTH, 4, src1 FIFO entries; power of two, 2..16.
- ACC_W, 32, phase accumulator width; must hold CLOCK_HZ+FS_HZ.

Ports:
- vga_clk_sig  in  1  clock; all logic on rising edge.
- reset_sig  in  1  asynchronous, active-high reset.
- sel_mode  in  2  00 auto, 01 force src0, 10 force src1, 11 mute.
- src0_l  in  DATA_W  src0 left level, sampled on tick.
- src0_r  in  DATA_W  src0 right level, sampled on tick.
- src1_valid  in  1  src1 sample offered.
- src1_ready  out  1  FIFO not full.
- src1_l  in  DATA_W  src1 left sample.
- src1_r  in  DATA_W  src1 right sample.
- pcm_fs  out  1  sample strobe to hdmi_tx, ~50% duty.
- pcm_l  out  DATA_W  left sample to hdmi_tx.
- pcm_r  out  DATA_W  right sample to hdmi_tx.
- active_src  out  1  0 = src0 is the current source, 1 = src1.
- underrun  out  1  one-cycle pulse when src1 is selected and the FIFO is empty at a tick.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async):
  - acc=0, pcm_fs=0, pcm_l=pcm_r=0, active_src=0 (state SRC0), underrun=0, FIFO empty, fifo_level=0.
  - src1_ready = ~full, combinational; it is therefore 1 during and after reset.
- Accumulator, every cycle:
  - If acc+FS_HZ >= CLOCK_HZ: tick=1 and acc <= acc+FS_HZ-CLOCK_HZ.
  - Otherwise: acc <= acc+FS_HZ.
  - The average tick rate is exactly FS_HZ; the interval is floor or ceil of CLOCK_HZ/FS_HZ.
- pcm_fs:
  - Set on the tick edge.
  - Cleared on the first edge where acc_next >= CLOCK_HZ/2 (integer division) and acc < CLOCK_HZ/2.
  - If a tick and a clear coincide, the tick wins.
- FIFO push: src1_valid && src1_ready writes {src1_l, src1_r}. src1_ready does not depend on a same-cycle pop, so a full FIFO refuses the push.
- FIFO pop: on a tick, only when the selected source is src1 and the FIFO is non-empty.
- Simultaneous push and pop: level is unchanged and pointers wrap modulo FIFO_DEPTH.
- Output update on the tick edge (same edge pcm_fs rises; zero extra latency):
  - Source src0: pcm <= src0.
  - Source src1, FIFO non-empty: pcm <= FIFO head.
  - Source src1, FIFO empty: pcm <= 0 and underrun pulses.
  - Mute: pcm <= 0, no pop.
- pcm_l and pcm_r are stable between ticks.
- Source state machine (evaluated only on tick edges; active_src follows the state):
  - Auto, SRC0 -> SRC1 when fifo_level >= FIFO_DEPTH/2. The new source takes effect at this same tick and the head is popped.
  - Auto, SRC1 -> SRC0 when the FIFO is empty at a tick. That tick outputs src0, with no underrun pulse.
  - Force src0 / force src1: state jumps to the forced source at the next tick. Forced src1 with an empty FIFO outputs 0 and pulses underrun.
  - Mute: the state holds.
- sel_mode changes between ticks have no effect until the next tick.

Optional Feature:
- Macro: HDMI_AUDIO_SCHED_HOLD_EN.
- Defined: an underrun repeats the last output sample instead of 0, and mute still outputs 0. underrun still pulses.
- Undefined: an underrun outputs 0, as specified above.

Test Plan:
- Exact tick spacing: CLOCK_HZ=1000, FS_HZ=100, sel_mode=01, src0=24'h123456/24'hABCDEF.
  - Required: pcm_fs rises every 10 cycles and is high 5 cycles.
  - Required: pcm_l=123456, pcm_r=ABCDEF from the first tick.
- Fractional rate: CLOCK_HZ=1000, FS_HZ=300, run 10000 cycles.
  - Required: exactly 3000 ticks.
  - Required: every interval is 3 or 4 cycles.
- Auto switch: FIFO_DEPTH=4, push 2 samples (1,2), then 0.
  - Required: the next tick outputs 1 with active_src=1, then 2.
  - Required: the following tick outputs src0 with active_src=0 and no underrun.
- Full FIFO: hold src1_valid=1 with no ticks.
  - Required: 4 pushes accepted, src1_ready=0, fifo_level=4.
  - Required: a tick pop with src1_valid still high gives level 4 after the next push.
- Underrun: sel_mode=10 with an empty FIFO.
  - Required: pcm=0 and a 1-cycle underrun pulse at each tick.
  - With HOLD_EN: pcm repeats the last sample.
- Reset mid-operation: assert reset_sig with FIFO level 3 and pcm_fs high.
  - Required: all outputs immediately go to their reset values and fifo_level=0.
  - Required: the first tick comes ceil(CLOCK_HZ/FS_HZ) cycles after release.
